// File: rtl/gpio_scan_ctrl_pkg.sv
// gpio_scan_ctrl_pkg: shared bus addresses, display modes, FSM states and LED selection helper
package gpio_scan_ctrl_pkg;

  localparam logic       GPIO_ADR_SW  = 1'b0;
  localparam logic       GPIO_ADR_LED = 1'b1;
  localparam logic [1:0] GPIO_SEL     = 2'b01;

  typedef enum logic [1:0] {
    GPIO_MODE_MIRROR = 2'd0,
    GPIO_MODE_BLINK  = 2'd1,
    GPIO_MODE_STATIC = 2'd2,
    GPIO_MODE_OFF    = 2'd3
  } gpio_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_UPD  = 2'd2,
    ST_WR   = 2'd3
  } scan_state_e;

  // LED value for a display mode; sw is the debounced switch value after this scan's update
  function automatic logic [7:0] led_value(input gpio_mode_e mode, input logic [7:0] pattern,
                                           input logic phase, input logic [7:0] sw);
    case (mode)
      GPIO_MODE_MIRROR: return sw;
      GPIO_MODE_BLINK:  return pattern & {8{phase}};
      GPIO_MODE_STATIC: return pattern;
      default:          return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/gpio_scan_ctrl_sw_debounce.sv
// sw_debounce: accepts a sample value once DEB_CNT consecutive equal samples have been seen
module sw_debounce #(
  parameter int W       = 8,
  parameter int DEB_CNT = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] sample_i,
  input  logic         sample_vld_i,
  output logic [W-1:0] stable_o,
  output logic         changed_o
);

  localparam int CW = $clog2(DEB_CNT);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CNT - 1);

  logic [W-1:0]  last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  stable_q, stable_d;

  // one debounce step per valid sample; the stable value follows once the run count saturates
  always_comb begin
    last_d    = last_q;
    cnt_d     = cnt_q;
    stable_d  = stable_q;
    changed_o = 1'b0;
    if (sample_vld_i) begin
      if (sample_i != last_q) begin
        last_d = sample_i;
        cnt_d  = '0;
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + 1'b1;
      end
      if (cnt_d == CNT_MAX && last_d != stable_q) begin
        stable_d  = last_d;
        changed_o = 1'b1;
      end
    end
  end

  // debounce state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_q   <= '0;
      cnt_q    <= '0;
      stable_q <= '0;
    end else begin
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/gpio_scan_ctrl.sv
// gpio_scan_ctrl: Wishbone master that periodically reads switches, debounces them and refreshes LEDs
module gpio_scan_ctrl
  import gpio_scan_ctrl_pkg::*;
#(
  parameter int TICK_DIV    = 50000,
  parameter int DEB_CNT     = 4,
  parameter int BLINK_TICKS = 8,
  parameter int TO_CYC      = 15
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  output logic        m_adr_o,
  output logic [15:0] m_dat_o,
  input  logic [15:0] m_dat_i,
  output logic [1:0]  m_sel_o,
  output logic        m_we_o,
  output logic        m_stb_o,
  output logic        m_cyc_o,
  input  logic        m_ack_i,
  input  logic        en_i,
  input  logic [1:0]  mode_i,
  input  logic [7:0]  pattern_i,
  input  logic        irq_ack_i,
  output logic [7:0]  sw_stable_o,
  output logic        irq_o,
  output logic        err_o,
  output logic        busy_o
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam int OW = $clog2(TO_CYC + 1);
  localparam logic [TW-1:0] TICK_MAX  = TW'(TICK_DIV - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_TICKS - 1);
  localparam logic [OW-1:0] TO_MAX    = OW'(TO_CYC - 1);

  scan_state_e   state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [OW-1:0] to_q, to_d;
  logic [BW-1:0] blink_q, blink_d;
  logic          phase_q, phase_d;
  logic [7:0]    sample_q, sample_d;
  logic [7:0]    led_q, led_d;
  logic [7:0]    led_last_q, led_last_d;
  logic          led_valid_q, led_valid_d;
  logic          irq_q, irq_d;
  logic          err_q, err_d;
  logic          tick;
  logic          xfer;
  logic [7:0]    deb_stable;
  logic          deb_changed;
  logic          unused_dat_hi;

  assign unused_dat_hi = ^m_dat_i[15:8];

  sw_debounce #(
    .W      (8),
    .DEB_CNT(DEB_CNT)
  ) u_deb (
    .clk_i       (wb_clk_i),
    .rst_ni      (wb_rst_ni),
    .sample_i    (sample_q),
    .sample_vld_i(state_q == ST_UPD),
    .stable_o    (deb_stable),
    .changed_o   (deb_changed)
  );

  // scan tick: free-running divider while enabled, parked at zero otherwise
  always_comb begin
    tick   = en_i && (tick_q == TICK_MAX);
    tick_d = (!en_i || tick) ? '0 : tick_q + 1'b1;
    irq_d  = deb_changed || (irq_q && !irq_ack_i);
  end

  // scan sequencer: read switches, update debounce/blink, write LEDs only when the value must change
  always_comb begin
    state_d     = state_q;
    to_d        = '0;
    blink_d     = blink_q;
    phase_d     = phase_q;
    sample_d    = sample_q;
    led_d       = led_q;
    led_last_d  = led_last_q;
    led_valid_d = led_valid_q;
    err_d       = err_q;
    case (state_q)
      ST_IDLE: state_d = tick ? ST_RD : ST_IDLE;
      ST_RD: begin
        if (m_ack_i) begin
          sample_d = m_dat_i[7:0];
          state_d  = ST_UPD;
        end else if (to_q == TO_MAX) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      ST_UPD: begin
        blink_d = (blink_q == BLINK_MAX) ? '0 : blink_q + 1'b1;
        phase_d = (blink_q == BLINK_MAX) ? ~phase_q : phase_q;
        led_d   = led_value(gpio_mode_e'(mode_i), pattern_i, phase_d,
                            deb_changed ? sample_q : deb_stable);
        state_d = (!led_valid_q || led_d != led_last_q) ? ST_WR : ST_IDLE;
      end
      ST_WR: begin
        if (m_ack_i) begin
          led_last_d  = led_q;
          led_valid_d = 1'b1;
          state_d     = ST_IDLE;
        end else if (to_q == TO_MAX) begin
          err_d       = 1'b1;
          led_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state and datapath registers; async reset clears bus strobes immediately via state_q
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q     <= ST_IDLE;
      tick_q      <= '0;
      to_q        <= '0;
      blink_q     <= '0;
      phase_q     <= 1'b0;
      sample_q    <= '0;
      led_q       <= '0;
      led_last_q  <= '0;
      led_valid_q <= 1'b0;
      irq_q       <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      to_q        <= to_d;
      blink_q     <= blink_d;
      phase_q     <= phase_d;
      sample_q    <= sample_d;
      led_q       <= led_d;
      led_last_q  <= led_last_d;
      led_valid_q <= led_valid_d;
      irq_q       <= irq_d;
      err_q       <= err_d;
    end
  end

  // bus outputs decoded from the current state only
  always_comb begin
    xfer        = (state_q == ST_RD) || (state_q == ST_WR);
    m_cyc_o     = xfer;
    m_stb_o     = xfer;
    m_we_o      = state_q == ST_WR;
    m_adr_o     = (state_q == ST_WR) ? GPIO_ADR_LED : GPIO_ADR_SW;
    m_sel_o     = xfer ? GPIO_SEL : 2'b00;
    m_dat_o     = (state_q == ST_WR) ? {8'h00, led_q} : 16'h0000;
    sw_stable_o = deb_stable;
    irq_o       = irq_q;
    err_o       = err_q;
    busy_o      = state_q != ST_IDLE;
  end

endmodule

// File: tb/tb_gpio_scan_ctrl.sv
// tb_gpio_scan_ctrl: randomized scan stimulus with a scoreboarded Wishbone monitor and scan-level model
module tb_gpio_scan_ctrl;

  localparam int TICK_DIV = 8;
  localparam int DEB      = 4;
  localparam int BLINK    = 2;
  localparam int TO       = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m_adr_o;
  logic [15:0] m_dat_o;
  logic [15:0] m_dat_i;
  logic [1:0]  m_sel_o;
  logic        m_we_o, m_stb_o, m_cyc_o, m_ack_i;
  logic        en_i = 1'b0;
  logic [1:0]  mode_i = 2'd0;
  logic [7:0]  pattern_i = 8'h00;
  logic        irq_ack_i = 1'b0;
  logic [7:0]  sw_stable_o;
  logic        irq_o, err_o, busy_o;

  always #5 clk = ~clk;

  gpio_scan_ctrl #(
    .TICK_DIV   (TICK_DIV),
    .DEB_CNT    (DEB),
    .BLINK_TICKS(BLINK),
    .TO_CYC     (TO)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_ni  (rst_n),
    .m_adr_o    (m_adr_o),
    .m_dat_o    (m_dat_o),
    .m_dat_i    (m_dat_i),
    .m_sel_o    (m_sel_o),
    .m_we_o     (m_we_o),
    .m_stb_o    (m_stb_o),
    .m_cyc_o    (m_cyc_o),
    .m_ack_i    (m_ack_i),
    .en_i       (en_i),
    .mode_i     (mode_i),
    .pattern_i  (pattern_i),
    .irq_ack_i  (irq_ack_i),
    .sw_stable_o(sw_stable_o),
    .irq_o      (irq_o),
    .err_o      (err_o),
    .busy_o     (busy_o)
  );

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // slave: switches on read data, programmable wait states, optional refusal to ack writes
  logic [7:0] sw_i = 8'h00;
  logic       block_wr = 1'b0;
  int         wait_min = 0, wait_max = 0, wait_cnt = 0, wait_req = 0;

  assign m_ack_i = m_cyc_o && m_stb_o && (wait_cnt >= wait_req) && !(block_wr && m_we_o);
  assign m_dat_i = {8'hEE, sw_i};

  always @(posedge clk) begin
    if (m_stb_o && !m_ack_i) wait_cnt <= wait_cnt + 1;
    else begin
      wait_cnt <= 0;
      if (m_ack_i) wait_req <= int'($urandom_range(wait_max, wait_min));
    end
  end

  // irq acknowledge pulsed exactly in the update cycle (busy with no bus cycle)
  logic ack_upd_en = 1'b0;
  always @(negedge clk) irq_ack_i <= ack_upd_en && busy_o && !m_cyc_o;

  // length of the most recent strobe burst
  int run_cnt = 0, last_run = 0;
  always @(posedge clk) begin
    if (m_stb_o) run_cnt <= run_cnt + 1;
    else begin
      if (run_cnt != 0) last_run <= run_cnt;
      run_cnt <= 0;
    end
  end

  // scoreboard of completed bus transfers
  typedef struct packed {
    logic        we;
    logic [15:0] dat;
  } xfer_t;
  xfer_t exp_q[$];
  xfer_t e;

  always @(negedge clk) begin
    if (rst_n && m_cyc_o && m_stb_o && m_ack_i) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_xfer got we=%b dat=%h expected none t=%0t", m_we_o, m_dat_o, $time);
      end else begin
        e = exp_q.pop_front();
        check("xfer_we", m_we_o, e.we);
        check("xfer_adr", m_adr_o, e.we);
        check("xfer_sel", m_sel_o, 2'b01);
        if (e.we) check("xfer_wdat", m_dat_o, e.dat);
      end
    end
  end

  // scan-level reference model
  int          m_scans;
  logic [7:0]  m_hist[$];
  logic [7:0]  m_stable, m_last;
  bit          m_valid, m_irq;

  task automatic model_reset();
    m_scans = 0;
    m_hist.delete();
    m_stable = 8'h00;
    m_last = 8'h00;
    m_valid = 0;
    m_irq = 0;
    exp_q.delete();
  endtask

  task automatic model_scan(input logic [7:0] sw, input bit wr_ok, input bit ack);
    bit ch, eq, phase;
    logic [7:0] led;
    ch = 0;
    exp_q.push_back('{we: 1'b0, dat: 16'h0000});
    m_scans++;
    m_hist.push_back(sw);
    if (m_hist.size() > DEB) m_hist.delete(0);
    if (m_hist.size() == DEB) begin
      eq = 1;
      foreach (m_hist[i]) if (m_hist[i] != sw) eq = 0;
      if (eq && sw != m_stable) begin
        m_stable = sw;
        ch = 1;
      end
    end
    m_irq = ch ? 1'b1 : (ack ? 1'b0 : m_irq);
    phase = ((m_scans / BLINK) % 2) == 1;
    case (mode_i)
      2'd0:    led = m_stable;
      2'd1:    led = phase ? pattern_i : 8'h00;
      2'd2:    led = pattern_i;
      default: led = 8'h00;
    endcase
    if (!m_valid || led != m_last) begin
      if (wr_ok) begin
        exp_q.push_back('{we: 1'b1, dat: {8'h00, led}});
        m_valid = 1;
        m_last = led;
      end else m_valid = 0;
    end
  endtask

  task automatic wait_busy(input logic v, input int budget, input string what);
    int n;
    n = 0;
    while (busy_o !== v && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy_o !== v) begin
      total++;
      bad++;
      $display("FAIL %s busy=%b expected=%b after %0d cycles", what, busy_o, v, n);
    end
  endtask

  task automatic scan(input logic [7:0] sw, input bit wr_ok, input bit ack);
    sw_i = sw;
    block_wr = !wr_ok;
    ack_upd_en = ack;
    model_scan(sw, wr_ok, ack);
    wait_busy(1'b1, 4 * TICK_DIV, "scan_start");
    wait_busy(1'b0, 64, "scan_end");
    ack_upd_en = 0;
    block_wr = 0;
    check("sw_stable", sw_stable_o, m_stable);
    check("irq", irq_o, m_irq);
    check("xfers_done", exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  logic [7:0] cur;
  logic [7:0] bounce[6] = '{8'h5A, 8'hA5, 8'h5A, 8'h5A, 8'h5A, 8'h5A};
  int n, cnt;

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_bus", {m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_sel_o}, 0);
    check("rst_dat", m_dat_o, 0);
    check("rst_stable", sw_stable_o, 0);
    check("rst_flags", {irq_o, err_o, busy_o}, 0);
    rst_n = 1'b1;
    en_i = 1'b1;

    // steady switches: write 00 first, then A5 once debounced, then reads only
    repeat (6) scan(8'hA5, 1, 0);
    scan(8'hA5, 1, 1);

    // bounce toward 5A; acknowledge lands on the cycle the irq is set
    foreach (bounce[i]) scan(bounce[i], 1, i == 5);
    cur = 8'h5A;

    // blink, static and off modes with wait states
    wait_max = 2;
    mode_i = 2'd1;
    pattern_i = 8'h3C;
    repeat (8) scan(cur, 1, 0);
    mode_i = 2'd2;
    repeat (3) scan(cur, 1, 0);
    mode_i = 2'd3;
    repeat (2) scan(cur, 1, 0);

    // randomized scans
    repeat (40) begin
      if ($urandom_range(0, 3) == 0) cur = $urandom_range(0, 1) ? 8'h11 : 8'hEE;
      if ($urandom_range(0, 3) == 0) mode_i = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) pattern_i = 8'($urandom);
      scan(cur, 1, 1'($urandom_range(0, 1)));
    end

    // write timeout then retry on a good slave
    wait_max = 0;
    mode_i = 2'd2;
    pattern_i = m_last ^ 8'hFF;
    scan(cur, 0, 0);
    repeat (2) @(negedge clk);
    check("to_stb_len", last_run, TO);
    check("to_err", err_o, 1);
    check("to_busy", busy_o, 0);
    scan(cur, 1, 0);

    // asynchronous reset in the middle of a write
    pattern_i = m_last ^ 8'h0F;
    block_wr = 1'b1;
    sw_i = cur;
    exp_q.push_back('{we: 1'b0, dat: 16'h0000});
    wait_busy(1'b1, 4 * TICK_DIV, "rst_scan_start");
    n = 0;
    while (!m_we_o && n < 64) begin
      @(negedge clk);
      n++;
    end
    check("rst_wr_reached", m_we_o, 1);
    check("rst_read_done", exp_q.size(), 0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_bus", {m_cyc_o, m_stb_o, m_we_o, m_adr_o, m_sel_o}, 0);
    check("arst_dat", m_dat_o, 0);
    check("arst_out", {sw_stable_o, irq_o, err_o, busy_o}, 0);
    block_wr = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    mode_i = 2'd0;
    scan(cur, 1, 0);

    // enable dropped during a read
    wait_min = 3;
    wait_max = 3;
    scan(cur, 1, 0);
    sw_i = cur;
    model_scan(cur, 1, 0);
    wait_busy(1'b1, 4 * TICK_DIV, "dis_scan_start");
    check("dis_in_rd", {m_stb_o, m_we_o}, 2'b10);
    en_i = 1'b0;
    wait_busy(1'b0, 64, "dis_scan_end");
    check("dis_xfers_done", exp_q.size(), 0);
    cnt = 0;
    repeat (4 * TICK_DIV) begin
      @(negedge clk);
      if (m_cyc_o) cnt++;
    end
    check("dis_no_cycles", cnt, 0);
    model_scan(cur, 1, 0);
    en_i = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!m_stb_o && n < 4 * TICK_DIV);
    check("reen_latency", n, TICK_DIV);
    wait_busy(1'b0, 64, "reen_scan_end");
    check("reen_xfers_done", exp_q.size(), 0);
    check("reen_stable", sw_stable_o, m_stable);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
